mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_pkg.sv | 19 +
 rtl/mul_sequencer.sv | 134 +++++++++++++
 tb/tb_mul_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared ALU definitions for the sequential multiplier.
// Provides the default operand width, the FSM state encoding and the
// MUL / SMUL opcode constants used to select unsigned or signed multiply.
package mul_sequencer_pkg;

  localparam int MUL_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  typedef enum logic {
    OP_MUL  = 1'b0,
    OP_SMUL = 1'b1
  } mul_op_e;

endpackage

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier (one multiplier bit per clock, LSB first).
//
// Ports:
//   Clock      - single clock, all state on the rising edge
//   Reset      - asynchronous active-high reset
//   iStart     - begin a multiply with the current operands (IDLE or DONE only)
//   iSigned    - 1 = two's-complement multiply, 0 = unsigned; sampled with iStart
//   iFlush     - abort an operation in progress (RUN only), wins over iStart
//   iOperandA  - multiplicand, WIDTH bits
//   iOperandB  - multiplier, WIDTH bits
//   oBusy      - high while in RUN
//   oDone      - one-cycle pulse when oResult has just been loaded
//   oResult    - last completed 2*WIDTH product, held until the next completion
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iSigned,
  input  logic               iFlush,
  input  logic [WIDTH-1:0]   iOperandA,
  input  logic [WIDTH-1:0]   iOperandB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult
);

  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int PROD_W = 2 * WIDTH;

  // Magnitude of an operand. For the most negative value the W-bit two's
  // complement wraps back onto itself, which read as unsigned is exactly
  // 2^(WIDTH-1) -- the correct magnitude, so no extra bit is needed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    if (is_signed && sv < 0) begin
      return (~v) + WIDTH'(1);
    end
    return v;
  endfunction

  function automatic logic [PROD_W-1:0] negate(input logic [PROD_W-1:0] v);
    return (~v) + PROD_W'(1);
  endfunction

  mul_state_e          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [PROD_W-1:0]   acc_q,    acc_d;
  logic [PROD_W-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic                neg_q,    neg_d;
  logic [PROD_W-1:0]   result_q, result_d;

  mul_op_e             op;
  logic [PROD_W-1:0]   step_sum;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    result_d = result_q;

    op       = iSigned ? OP_SMUL : OP_MUL;
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart) begin
          // Operands are reduced to magnitudes here; the sign of the product
          // is remembered separately and applied once at completion.
          state_d  = ST_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, magnitude(iOperandA, op == OP_SMUL)};
          mplier_d = magnitude(iOperandB, op == OP_SMUL);
          neg_d    = (op == OP_SMUL) && (iOperandA[WIDTH-1] ^ iOperandB[WIDTH-1]);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (iFlush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = step_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = neg_q ? negate(step_sum) : step_sum;
            state_d  = ST_DONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Status outputs depend on the state register only.
  assign oBusy   = (state_q == ST_RUN);
  assign oDone   = (state_q == ST_DONE);
  assign oResult = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: a transaction-level model predicts busy/done/result
// every cycle, plus directed cases with hand-computed products and latencies.
module tb_mul_sequencer;

  localparam int W = 16;

  logic           Clock = 1'b0;
  logic           Reset;
  logic           iStart;
  logic           iSigned;
  logic           iFlush;
  logic [W-1:0]   iOperandA;
  logic [W-1:0]   iOperandB;
  logic           oBusy;
  logic           oDone;
  logic [2*W-1:0] oResult;

  int     checks = 0;
  int     errors = 0;
  logic   check_en = 1'b0;
  longint cyc = 0;
  longint acc_cyc = 0;

  always #5 Clock = ~Clock;

  mul_sequencer #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iSigned   (iSigned),
    .iFlush    (iFlush),
    .iOperandA (iOperandA),
    .iOperandB (iOperandB),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oResult   (oResult)
  );

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint x, y;
    logic [63:0] p;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    p = 64'(x * y);
    return p[2*W-1:0];
  endfunction

  // Transaction model: an accepted start schedules a completion W edges later.
  int             m_left;
  logic           m_done;
  logic [2*W-1:0] m_res;
  logic [2*W-1:0] m_pend;

  always @(posedge Clock or posedge Reset) begin : model
    int             l;
    logic           d;
    logic [2*W-1:0] r;
    logic [2*W-1:0] p;
    if (Reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_pend <= '0;
    end else begin
      l = m_left;
      d = 1'b0;
      r = m_res;
      p = m_pend;
      if (l > 0) begin
        if (iFlush) begin
          l = 0;
        end else begin
          l = l - 1;
          if (l == 0) begin
            r = p;
            d = 1'b1;
          end
        end
      end else if (iStart) begin
        p = ref_mul(iOperandA, iOperandB, iSigned);
        l = W;
      end
      m_left <= l;
      m_done <= d;
      m_res  <= r;
      m_pend <= p;
    end
  end

  always @(negedge Clock) begin
    if (check_en) begin
      chk("model_busy",   64'(oBusy),   64'(m_left > 0));
      chk("model_done",   64'(oDone),   64'(m_done));
      chk("model_result", 64'(oResult), 64'(m_res));
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge Clock);
    #1;
    iOperandA = a;
    iOperandB = b;
    iSigned   = s;
    iStart    = 1'b1;
    @(posedge Clock);
    #1;
    acc_cyc = cyc;
    iStart  = 1'b0;
  endtask

  task automatic wait_done(input logic [2*W-1:0] lit, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge Clock);
      if (oDone === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 64'(0), 64'(1));
    end else begin
      chk({name, "_latency"}, 64'(cyc - acc_cyc), 64'(W));
      chk(name, 64'(oResult), 64'(lit));
    end
  endtask

  task automatic count_dones(input int ncyc, input string name);
    int cnt;
    cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge Clock);
      if (oDone === 1'b1) cnt++;
    end
    chk(name, 64'(cnt), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] corners [5];
    corners[0] = 16'h0000;
    corners[1] = 16'h0001;
    corners[2] = 16'hFFFF;
    corners[3] = 16'h8000;
    corners[4] = 16'h7FFF;

    Reset = 1'b0; iStart = 1'b0; iSigned = 1'b0; iFlush = 1'b0;
    iOperandA = '0; iOperandB = '0;
    #2 Reset = 1'b1;
    repeat (2) @(negedge Clock);
    chk("reset_busy",   64'(oBusy),   64'(0));
    chk("reset_done",   64'(oDone),   64'(0));
    chk("reset_result", 64'(oResult), 64'(0));
    #1 Reset = 1'b0;
    check_en = 1'b1;

    // Unsigned and signed products with hand-computed values.
    start_op(16'h0003, 16'h0005, 1'b0); wait_done(32'h0000000F, "u_3x5");
    start_op(16'hFFFF, 16'hFFFF, 1'b0); wait_done(32'hFFFE0001, "u_ffffxffff");
    start_op(16'hFFFD, 16'h0005, 1'b1); wait_done(32'hFFFFFFF1, "s_m3x5");
    start_op(16'h8000, 16'h8000, 1'b1); wait_done(32'h40000000, "s_minxmin");
    start_op(16'h8000, 16'h0001, 1'b1); wait_done(32'hFFFF8000, "s_minx1");

    // Starts while running are ignored.
    start_op(16'h1234, 16'h0011, 1'b0);
    repeat (2) @(negedge Clock);
    #1 iStart = 1'b1; iOperandA = 16'hFFFF; iOperandB = 16'hFFFF; iSigned = 1'b1;
    @(negedge Clock);
    #1 iStart = 1'b0;
    repeat (6) @(negedge Clock);
    #1 iStart = 1'b1; iOperandA = 16'h0007; iOperandB = 16'h0009;
    @(negedge Clock);
    #1 iStart = 1'b0;
    wait_done(32'h00013574, "ign_start");
    count_dones(20, "ign_single_done");

    // Back-to-back start from DONE.
    start_op(16'h0007, 16'h0009, 1'b0);
    wait_done(32'h0000003F, "b2b_first");
    #1 iOperandA = 16'h0002; iOperandB = 16'h0004; iSigned = 1'b0; iStart = 1'b1;
    chk("b2b_hold", 64'(oResult), 64'h3F);
    @(posedge Clock);
    #1 acc_cyc = cyc; iStart = 1'b0;
    wait_done(32'h00000008, "b2b_second");

    // Flush in RUN cycle 7.
    start_op(16'h00FF, 16'h0101, 1'b0);
    repeat (6) @(negedge Clock);
    #1 iFlush = 1'b1;
    @(posedge Clock);
    #1 iFlush = 1'b0;
    @(negedge Clock);
    chk("flush_busy",   64'(oBusy),   64'(0));
    chk("flush_done",   64'(oDone),   64'(0));
    chk("flush_result", 64'(oResult), 64'h8);
    count_dones(20, "flush_no_done");

    // Asynchronous reset in the middle of RUN.
    start_op(16'h1111, 16'h2222, 1'b1);
    repeat (5) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("areset_busy",   64'(oBusy),   64'(0));
    chk("areset_done",   64'(oDone),   64'(0));
    chk("areset_result", 64'(oResult), 64'(0));
    #1 Reset = 1'b0;
    start_op(16'hFFFA, 16'hFFF9, 1'b1); wait_done(32'h0000002A, "after_reset");

    // Randomised traffic, checked every cycle against the model.
    for (int i = 0; i < 800; i++) begin
      @(negedge Clock);
      #1;
      iStart  = ($urandom % 3 == 0);
      iFlush  = ($urandom % 20 == 0);
      iSigned = 1'($urandom % 2);
      iOperandA = ($urandom % 4 == 0) ? corners[$urandom % 5] : W'($urandom);
      iOperandB = ($urandom % 4 == 0) ? corners[$urandom % 5] : W'($urandom);
    end
    @(negedge Clock);
    #1 iStart = 1'b0; iFlush = 1'b0;
    repeat (20) @(negedge Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
